accum_sampler: RTL
==================

# accum_sampler

Downstream consumer of the accumulator stage: samples the 64-bit accumulator output `x` at a programmable decimation interval and flags wrap-around (sample smaller than the previous sample). Samples go into a small FIFO and drain over a valid/ready stream to the host-side DPI reader. Samples lost to back-pressure are counted. Sits directly after the accumulator, driven by the same `clk`.

## Interface
- `WIDTH`, default 64: sample data width, matches the accumulator output.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `DIV_W`, default 16: width of the decimation divisor.
- `clk` in, 1: the single clock; all logic on posedge.
- `rst` in, 1: reset, synchronous and active-high.
- `x` in, WIDTH: accumulator value, sampled as-is.
- `en` in, 1: sampling enable; when low the divider holds and no samples are taken.
- `div` in, DIV_W: sample every `div+1` enabled cycles.
- `out_data` out, WIDTH: head-of-FIFO sample value.
- `out_wrap` out, 1: head sample is a wrap (value < previous sample).
- `out_valid` out, 1: head entry present.
- `out_ready` in, 1: consumer accepts the head this cycle.
- `level` out, $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `drop_cnt` out, 16: saturating count of samples dropped on full.

## Operation
- Divider `cnt` (DIV_W):
  - On `rst`, `cnt`=0.
  - When `en` and `cnt`==0: tick, then reload `cnt`=`div`.
  - When `en` and `cnt`!=0: decrement.
  - When `!en`: hold.
  - A new `div` value takes effect only at the next reload.
- Tick sampling: capture `x`. `wrap` = (`x` < `prev`) && `have_prev`. Then `prev` ← `x` and `have_prev` ← 1.
- `prev` updates on every tick, including ticks whose sample is dropped.
- Push accepted when `level` < DEPTH, or when a pop happens the same cycle.
- Otherwise the sample is dropped and `drop_cnt` increments, saturating at 16'hFFFF.
- Pop: `out_valid && out_ready`.
- Simultaneous push and pop: `level` unchanged.
- Push and pop on the same cycle with `level`==0 is impossible, since `out_valid`=0.
- `out_data`/`out_wrap` read 0 when `out_valid`=0, and are stable while `out_valid && !out_ready`.
- Pointers wrap modulo DEPTH. `level` distinguishes full from empty.
- Reset mid-stream: FIFO emptied, `have_prev`=0, `drop_cnt`=0, `cnt`=0. All contents discarded; no partial drain.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_wrap`=0, `level`=0, `drop_cnt`=0.
- Tick at edge N: entry is written at edge N; `out_valid`=1 and `level` updated after edge N (one-cycle latency from the sampled `x` to the output).
- `x` sampled is the value present before edge N, i.e. the accumulator's registered output.
- With `div`=0 and `en`=1, every cycle ticks.
- `out_ready` is combinationally consumed; there is no combinational path from `out_ready` to `out_valid`.
- Full-FIFO drop and `drop_cnt` increment land on the same edge as the tick.

## Configuration
- `ACCUM_SAMPLER_TRACE_EN` defined:
  - Each tick prints `"%m: sample = %0d wrap = %0b"`, prefixed `"DROP "` when dropped.
  - `final` prints `"%m: drops = %0d"`.
- Undefined: no `$display`/`final`; RTL is otherwise identical and cycle-equivalent.

## Structure
- Package `accum_pkg`:
  - `ACCUM_W` = 64.
  - `typedef struct packed { logic wrap; logic [ACCUM_W-1:0] data; } accum_sample_t`.
  - Saturating-increment function for `drop_cnt`.
- Sub-module `accum_sampler_fifo`: storage, pointers, `level`, valid/ready pop, zero-on-empty output.
- Top: divider, wrap compare, drop counter, trace.

## Test plan
- Basic stream:
  - Stimulus: `rst` 2 cycles; `div`=0, `en`=1, `out_ready`=1; `x` = 0,1,2,3…
  - Required: `out_data` = 0,1,2,3 each one cycle after sampling; `out_wrap`=0 throughout; `level` ≤1; `drop_cnt`=0.
- Decimation:
  - Stimulus: `div`=3, `x` incrementing from 10.
  - Required: samples 10,14,18,22; `en` low for 5 cycles mid-run shifts subsequent samples by exactly 5.
- Wrap:
  - Stimulus: `x` = 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1.
  - Required: `out_wrap` = 0,0,1,0. The first sample after reset has wrap=0 even if `x`=0.
- Back-pressure:
  - Stimulus: `out_ready`=0, `div`=0, 7 ticks with DEPTH=4.
  - Required: `level`=4, `drop_cnt`=3, head held at the first sample. Then `out_ready`=1 with continued ticks: `level` stays 4 (simultaneous push/pop), drops stop.
- Saturation: force `drop_cnt` near max via 65540 drops → reads 16'hFFFF, no wrap to 0.
- Reset mid-operation:
  - Stimulus: `rst` with `level`=3.
  - Required: next cycle `out_valid`=0, `out_data`=0, `level`=0, `drop_cnt`=0. Next sample has wrap=0 regardless of value.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator sampler: sample record layout
// and the saturating counter step used by the drop counter.
package accum_pkg;

   localparam int ACCUM_W = 64;
   localparam int DROP_W  = 16;

   typedef struct packed {
      logic               wrap;
      logic [ACCUM_W-1:0] data;
   } accum_sample_t;

   // Sticks at all-ones so a long overload never reads back as a small count.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/accum_sampler_fifo.sv
// Sample FIFO: power-of-two storage, wrapping pointers, occupancy level and a
// valid/ready head that reads as zero while empty.
module accum_sampler_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   push_wrap,
   output logic                   push_accept,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_wrap,
   output logic                   out_valid,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] data_mem [DEPTH];
   logic             wrap_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop;

   assign out_valid   = (level != '0);
   assign pop         = out_valid && out_ready;
   // A full FIFO still takes a sample when the head leaves on the same edge.
   assign push_accept = push && ((level < FULL) || pop);
   assign out_data    = out_valid ? data_mem[rd_ptr] : '0;
   assign out_wrap    = out_valid ? wrap_mem[rd_ptr] : 1'b0;

   always_ff @(posedge clk) begin
      if (push_accept) begin
         data_mem[wr_ptr] <= push_data;
         wrap_mem[wr_ptr] <= push_wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/accum_sampler.sv
// Decimating sampler for the accumulator output with wrap detection, FIFO
// buffering and a saturating drop counter. Optional trace: ACCUM_SAMPLER_TRACE_EN.
module accum_sampler
   import accum_pkg::*;
#(
   parameter int WIDTH = ACCUM_W,
   parameter int DEPTH = 4,
   parameter int DIV_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       x,
   input  logic                   en,
   input  logic [DIV_W-1:0]       div,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_wrap,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic [DROP_W-1:0]      drop_cnt
);

   logic [DIV_W-1:0] cnt;
   logic [WIDTH-1:0] prev;
   logic             have_prev;
   logic             tick;
   logic             wrap;
   logic             push_accept;
   logic             drop;

   assign tick = en && (cnt == '0);
   assign wrap = have_prev && (x < prev);
   assign drop = tick && !push_accept;

   // div is only looked at on reload, so mid-interval changes wait their turn.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == '0) ? div : cnt - 1'b1;
   end

   // The wrap reference follows every tick, dropped or not.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= '0;
         have_prev <= 1'b0;
      end else if (tick) begin
         prev      <= x;
         have_prev <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop)
         drop_cnt <= sat_inc(drop_cnt);
   end

   accum_sampler_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (tick),
      .push_data   (x),
      .push_wrap   (wrap),
      .push_accept (push_accept),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_wrap    (out_wrap),
      .out_valid   (out_valid),
      .level       (level)
   );

`ifdef ACCUM_SAMPLER_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst && tick) begin
         if (drop)
            $display("DROP %m: sample = %0d wrap = %0b", x, wrap);
         else
            $display("%m: sample = %0d wrap = %0b", x, wrap);
      end
   end

   final $display("%m: drops = %0d", drop_cnt);
`else
`endif

endmodule
